// File: rtl/stack_arbiter.sv
// Round-robin arbiter sharing one LIFO stack between NUM_REQ requesters.
// Serialises push/pop grants onto the stack ports, tracks occupancy so the
// stack never wraps, and steers pop results back to the granted requester.
module stack_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int STACK_WIDTH = 18,
  parameter int DEPTH       = 16,
  parameter int CNT_BITS    = $clog2(DEPTH + 1)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [NUM_REQ-1:0]             i_req,
  input  logic [NUM_REQ-1:0]             i_req_op,
  input  logic [NUM_REQ*STACK_WIDTH-1:0] i_req_data,
  input  logic                           i_flush,
  output logic [NUM_REQ-1:0]             o_ack,
  output logic [NUM_REQ-1:0]             o_rvalid,
  output logic [STACK_WIDTH-1:0]         o_rdata,
  output logic [CNT_BITS-1:0]            o_count,
  output logic                           o_full,
  output logic                           o_empty,
  output logic                           o_stk_push,
  output logic                           o_stk_pop,
  output logic [STACK_WIDTH-1:0]         o_stk_data,
  output logic                           o_stk_rst,
  input  logic [STACK_WIDTH-1:0]         i_stk_data
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int STAGES = 2;

  logic [NUM_REQ-1:0][STACK_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]                  elig;
  logic                                push_ok, pop_ok;
  logic                                gnt_vld, gnt_push;
  logic [IDX_W-1:0]                    gnt_idx, cand_idx;

  logic [IDX_W-1:0]                    ptr_q, ptr_d;
  logic [CNT_BITS-1:0]                 count_q, count_d;
  logic [NUM_REQ-1:0]                  ack_q, rvalid_q;
  logic [STACK_WIDTH-1:0]              rdata_q, stk_data_q;
  logic                                stk_push_q, stk_pop_q, stk_rst_q;
  // Pop tags: valid bit and requester index travel together down the pipe
  logic [STAGES-1:0]                   vld_pipe_q;
  logic [STAGES-1:0][IDX_W-1:0]        idx_pipe_q;

  assign req_data = i_req_data;
  assign push_ok  = count_q < CNT_BITS'(DEPTH);
  assign pop_ok   = count_q != '0;

  // Per-requester eligibility against the registered occupancy
  always_comb begin
    elig = '0;
    for (int k = 0; k < NUM_REQ; k++)
      elig[k] = i_req[k] & (i_req_op[k] ? push_ok : pop_ok);
  end

  // Round-robin search starting just after the last granted index
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = ptr_q;
    cand_idx = ptr_q;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_idx = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!gnt_vld && elig[cand_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand_idx;
      end
    end
    if (i_flush) gnt_vld = 1'b0;
    gnt_push = i_req_op[gnt_idx];
  end

  // Next occupancy and pointer; flush empties the stack but keeps fairness
  always_comb begin
    count_d = count_q;
    ptr_d   = ptr_q;
    if (i_flush) begin
      count_d = '0;
    end else if (gnt_vld) begin
      ptr_d   = gnt_idx;
      count_d = gnt_push ? count_q + 1'b1 : count_q - 1'b1;
    end
  end

  // Grant outputs, stack drive and state registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q      <= IDX_W'(NUM_REQ - 1);
      count_q    <= '0;
      ack_q      <= '0;
      stk_push_q <= 1'b0;
      stk_pop_q  <= 1'b0;
      stk_data_q <= '0;
      stk_rst_q  <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      count_q    <= count_d;
      ack_q      <= gnt_vld ? (NUM_REQ'(1) << gnt_idx) : '0;
      stk_push_q <= gnt_vld & gnt_push;
      stk_pop_q  <= gnt_vld & ~gnt_push;
      if (gnt_vld && gnt_push) stk_data_q <= req_data[gnt_idx];
      stk_rst_q  <= i_flush;
    end
  end

  // Pop return path: stack executes one edge after grant, capture one later
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_pipe_q <= '0;
      idx_pipe_q <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
    end else begin
      vld_pipe_q    <= {vld_pipe_q[0], gnt_vld & ~gnt_push};
      idx_pipe_q[0] <= gnt_idx;
      idx_pipe_q[1] <= idx_pipe_q[0];
      rvalid_q      <= vld_pipe_q[1] ? (NUM_REQ'(1) << idx_pipe_q[1]) : '0;
      if (vld_pipe_q[1]) rdata_q <= i_stk_data;
    end
  end

  assign o_ack      = ack_q;
  assign o_rvalid   = rvalid_q;
  assign o_rdata    = rdata_q;
  assign o_count    = count_q;
  assign o_full     = count_q == CNT_BITS'(DEPTH);
  assign o_empty    = count_q == '0;
  assign o_stk_push = stk_push_q;
  assign o_stk_pop  = stk_pop_q;
  assign o_stk_data = stk_data_q;
  assign o_stk_rst  = stk_rst_q;

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter with a behavioural stack attached.
module tb_stack_arbiter;
  localparam int N = 4, W = 18, D = 16, CB = 5;

  logic           clk = 1'b0, rst;
  logic [N-1:0]   req, req_op, ack, rvalid;
  logic [N*W-1:0] req_data;
  logic           flush, full, empty, stk_push, stk_pop, stk_rst;
  logic [W-1:0]   rdata, stk_wdata, stk_out;
  logic [CB-1:0]  count;

  int total = 0, passed = 0;

  always #5 clk = ~clk;

  stack_arbiter #(.NUM_REQ(N), .STACK_WIDTH(W), .DEPTH(D)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_op(req_op),
    .i_req_data(req_data), .i_flush(flush), .o_ack(ack), .o_rvalid(rvalid),
    .o_rdata(rdata), .o_count(count), .o_full(full), .o_empty(empty),
    .o_stk_push(stk_push), .o_stk_pop(stk_pop), .o_stk_data(stk_wdata),
    .o_stk_rst(stk_rst), .i_stk_data(stk_out)
  );

  // Behavioural stack: synchronous ops, registered pop output
  logic [W-1:0] mem [D];
  int sp;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= 0; stk_out <= '0;
    end else if (stk_rst) begin
      sp <= 0;
    end else if (stk_push && sp < D) begin
      mem[sp] <= stk_wdata; sp <= sp + 1;
    end else if (stk_pop && sp > 0) begin
      stk_out <= mem[sp-1]; sp <= sp - 1;
    end
  end

  typedef struct {
    logic         rst;
    logic [N-1:0] req, op;
    logic [W-1:0] dat;
    logic         flush;
    logic [N-1:0] ack;
    logic         push, pop;
    logic [CB-1:0] cnt;
    logic [N-1:0] rv;
    logic [W-1:0] rd;
    logic         srst;
  } vec_t;

  function automatic vec_t mk(logic r, logic [3:0] rq, logic [3:0] op, logic [17:0] dt,
                              logic fl, logic [3:0] ak, logic pu, logic po,
                              logic [4:0] ct, logic [3:0] rv, logic [17:0] rd, logic sr);
    vec_t v;
    v.rst = r; v.req = rq; v.op = op; v.dat = dt; v.flush = fl; v.ack = ak;
    v.push = pu; v.pop = po; v.cnt = ct; v.rv = rv; v.rd = rd; v.srst = sr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    req = '0; req_op = '0; flush = 1'b0; req_data = '0;
    rst = 1'b1; step(); rst = 1'b0;
  endtask

  vec_t vec [18];

  initial begin
    // push then pop from req0
    vec[0]  = mk(1, 4'b0001, 4'b0001, 18'h00A, 0, 4'b0001, 1, 0, 1, 4'b0000, 18'h0, 0);
    vec[1]  = mk(0, 4'b0001, 4'b0000, 18'h00A, 0, 4'b0001, 0, 1, 0, 4'b0000, 18'h0, 0);
    vec[2]  = mk(0, 4'b0000, 4'b0000, 18'h000, 0, 4'b0000, 0, 0, 0, 4'b0000, 18'h0, 0);
    vec[3]  = mk(0, 4'b0000, 4'b0000, 18'h000, 0, 4'b0000, 0, 0, 0, 4'b0001, 18'h00A, 0);
    // LIFO across requesters, pop while empty
    vec[4]  = mk(1, 4'b1000, 4'b1000, 18'h111, 0, 4'b1000, 1, 0, 1, 4'b0000, 18'h0, 0);
    vec[5]  = mk(0, 4'b1000, 4'b1000, 18'h222, 0, 4'b1000, 1, 0, 2, 4'b0000, 18'h0, 0);
    vec[6]  = mk(0, 4'b1000, 4'b1000, 18'h333, 0, 4'b1000, 1, 0, 3, 4'b0000, 18'h0, 0);
    vec[7]  = mk(0, 4'b0001, 4'b0000, 18'h000, 0, 4'b0001, 0, 1, 2, 4'b0000, 18'h0, 0);
    vec[8]  = mk(0, 4'b0010, 4'b0000, 18'h000, 0, 4'b0010, 0, 1, 1, 4'b0000, 18'h0, 0);
    vec[9]  = mk(0, 4'b0001, 4'b0000, 18'h000, 0, 4'b0001, 0, 1, 0, 4'b0001, 18'h333, 0);
    vec[10] = mk(0, 4'b0010, 4'b0000, 18'h000, 0, 4'b0000, 0, 0, 0, 4'b0010, 18'h222, 0);
    vec[11] = mk(0, 4'b0010, 4'b0000, 18'h000, 0, 4'b0000, 0, 0, 0, 4'b0001, 18'h111, 0);
    vec[12] = mk(0, 4'b0010, 4'b0000, 18'h000, 0, 4'b0000, 0, 0, 0, 4'b0000, 18'h0, 0);
    // pop in flight across a flush
    vec[13] = mk(1, 4'b0001, 4'b0001, 18'h055, 0, 4'b0001, 1, 0, 1, 4'b0000, 18'h0, 0);
    vec[14] = mk(0, 4'b0001, 4'b0000, 18'h055, 0, 4'b0001, 0, 1, 0, 4'b0000, 18'h0, 0);
    vec[15] = mk(0, 4'b0100, 4'b0100, 18'h0AB, 1, 4'b0000, 0, 0, 0, 4'b0000, 18'h0, 1);
    vec[16] = mk(0, 4'b0100, 4'b0100, 18'h0AB, 0, 4'b0100, 1, 0, 1, 4'b0001, 18'h055, 0);
    vec[17] = mk(0, 4'b0000, 4'b0000, 18'h000, 0, 4'b0000, 0, 0, 1, 4'b0000, 18'h0, 0);

    // Reset with all requesters pushing
    flush = 1'b0; req = 4'b1111; req_op = 4'b1111;
    req_data = {18'h103, 18'h102, 18'h101, 18'h100};
    rst = 1'b1;
    step(); step();
    chk("rst_ack",   32'(ack), 0);
    chk("rst_push",  32'(stk_push), 0);
    chk("rst_pop",   32'(stk_pop), 0);
    chk("rst_srst",  32'(stk_rst), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_count", 32'(count), 0);
    chk("rst_rvld",  32'(rvalid), 0);
    rst = 1'b0;

    // Continuous pushes fill the stack in round-robin order
    for (int i = 0; i < 16; i++) begin
      step();
      chk($sformatf("fill_ack%0d", i),  32'(ack), 32'(1 << (i % 4)));
      chk($sformatf("fill_cnt%0d", i),  32'(count), 32'(i + 1));
      chk($sformatf("fill_dat%0d", i),  32'(stk_wdata), 32'(18'h100 + (i % 4)));
    end
    chk("full_flag", 32'(full), 1);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("full_noack",  32'(ack), 0);
      chk("full_nopush", 32'(stk_push), 0);
      chk("full_cnt",    32'(count), 16);
    end

    // Full: req2 push blocked, req1 pop goes first
    req = 4'b0110; req_op = 4'b0100;
    step();
    chk("fp_ack_pop", 32'(ack), 32'(4'b0010));
    chk("fp_pop",     32'(stk_pop), 1);
    chk("fp_push0",   32'(stk_push), 0);
    chk("fp_cnt15",   32'(count), 15);
    req = 4'b0100;
    step();
    chk("fp_ack_push", 32'(ack), 32'(4'b0100));
    chk("fp_cnt16",    32'(count), 16);
    chk("fp_full",     32'(full), 1);
    req = '0;
    step();
    chk("fp_rvalid", 32'(rvalid), 32'(4'b0010));
    chk("fp_rdata",  32'(rdata), 32'(18'h103));
    step();
    chk("fp_rv_off", 32'(rvalid), 0);

    // Table-driven sequences
    for (int i = 0; i < 18; i++) begin
      if (vec[i].rst) do_reset();
      req = vec[i].req; req_op = vec[i].op; flush = vec[i].flush;
      req_data = {4{vec[i].dat}};
      step();
      chk($sformatf("v%0d_ack", i),   32'(ack), 32'(vec[i].ack));
      chk($sformatf("v%0d_push", i),  32'(stk_push), 32'(vec[i].push));
      chk($sformatf("v%0d_pop", i),   32'(stk_pop), 32'(vec[i].pop));
      chk($sformatf("v%0d_cnt", i),   32'(count), 32'(vec[i].cnt));
      chk($sformatf("v%0d_full", i),  32'(full), 32'(vec[i].cnt == 16));
      chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vec[i].cnt == 0));
      chk($sformatf("v%0d_rvld", i),  32'(rvalid), 32'(vec[i].rv));
      chk($sformatf("v%0d_srst", i),  32'(stk_rst), 32'(vec[i].srst));
      if (vec[i].rv != '0) chk($sformatf("v%0d_rdata", i), 32'(rdata), 32'(vec[i].rd));
      if (vec[i].push)     chk($sformatf("v%0d_wdata", i), 32'(stk_wdata), 32'(vec[i].dat));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/stack_arbiter.md
Name: stack_arbiter

Overview:
- Round-robin arbiter that shares one stack instance between NUM_REQ requesters.
- Each requester issues push or pop requests over a req/ack handshake. The arbiter serialises them onto the stack's push/pop/data inputs.
- It keeps an occupancy count so the stack never wraps, and it routes pop data back to the requester that was granted.
- It sits between the requesting engines and the stack and is the only master of the stack's ports.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- STACK_WIDTH, 18, word width; must match the attached stack.
- DEPTH, 16, usable stack entries; must equal the attached stack's entry count.
- CNT_BITS, $clog2(DEPTH+1), width of the occupancy count (derived).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous reset, active-high.
- i_req  in  NUM_REQ  per-requester request; held high until acked.
- i_req_op  in  NUM_REQ  per-requester operation, 1=push, 0=pop; stable while i_req is high.
- i_req_data  in  NUM_REQ*STACK_WIDTH  push data, requester k at bits [k*STACK_WIDTH +: STACK_WIDTH].
- i_flush  in  1  discard stack contents.
- o_ack  out  NUM_REQ  one-hot, one-cycle pulse: request accepted.
- o_rvalid  out  NUM_REQ  one-hot, one-cycle pulse: o_rdata carries pop result for that requester.
- o_rdata  out  STACK_WIDTH  pop result.
- o_count  out  CNT_BITS  entries currently held.
- o_full  out  1  o_count == DEPTH.
- o_empty  out  1  o_count == 0.
- o_stk_push  out  1  to stack i_push.
- o_stk_pop  out  1  to stack i_pop.
- o_stk_data  out  STACK_WIDTH  to stack i_data.
- o_stk_rst  out  1  to stack i_rst.
- i_stk_data  in  STACK_WIDTH  from stack o_data.

Behaviour:
- Reset is asynchronous and active-high.
  - All outputs are 0, except o_empty=1.
  - count=0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
  - The rvalid pipeline is cleared.
- Eligibility is evaluated against the registered count:
  - A push request is eligible iff count < DEPTH.
  - A pop request is eligible iff count > 0.
  - An ineligible request is not acked and stays pending.
  - The arbiter never issues simultaneous push and pop.
- Arbitration, each edge with i_flush=0:
  - Grant the first eligible requester searching from pointer+1 upward, with wrap-around.
  - The pointer then moves to the granted index; it is unchanged if nothing is granted.
  - At most one grant per cycle; back-to-back grants are allowed every cycle.
- Grant at edge E0, all registered at E0:
  - o_ack[k]=1.
  - Push: o_stk_push=1 and o_stk_data=requester k's data.
  - Pop: o_stk_pop=1.
  - count is +1 for a push and -1 for a pop.
- Pop latency: the stack executes at E1. At E2 the arbiter registers o_rdata<=i_stk_data and o_rvalid[k]=1. Result: rvalid is high 2 cycles after ack.
- Pipeline: up to 2 pops are in flight. The requester index travels with its pipeline stage.
- Ordering is strict LIFO across all requesters. A push acked at E0 followed by a pop acked at E1 returns that pushed word.
- o_stk_push and o_stk_pop are single-cycle pulses per grant; both are 0 with no grant.
- Flush:
  - When i_flush is sampled high at edge Ef: no grant at Ef, count<=0, o_stk_rst=1 for exactly one cycle (after Ef).
  - Pointer is unchanged.
  - Pops acked before Ef still complete with valid data: the capture at E2 precedes the stack reset.
  - Pending requests are re-arbitrated after flush; pops stay pending until count > 0.
- o_full and o_empty are derived from the registered count and update on the same edge as count.
- Requester behaviour is undefined if i_req_op changes while i_req is high without an ack.

Test Plan:
- Reset with i_req=4'b1111 held during reset, then release → no ack, o_stk_* =0, o_empty=1 while i_rst=1. First grant after release goes to requester 0.
- Req0 pushes 18'h00A, then pops → o_ack[0] pulses twice. Two cycles after the second ack, o_rvalid[0]=1 and o_rdata=18'h00A. count goes 0→1→0.
- Requesters 0–3 all push continuously → acks in order 0,1,2,3,0,… one per cycle. After 16 acks o_full=1 and further pushes stay unacked with o_stk_push=0.
- Full stack with requester 2 pushing and requester 1 popping → only the pop is acked. The next cycle the push is acked; count returns to 16.
- Push 18'h111, 18'h222, 18'h333 from req 3, then pops from reqs 0 and 1 alternately → req0 gets 18'h333, req1 gets 18'h222, req0 gets 18'h111. No ack for a 4th pop while o_empty=1.
- Pop acked at E0, i_flush at E1 → o_rvalid with the correct word still delivered at E2. o_stk_rst pulses for one cycle, count=0, and no ack at E1.
